// File: rtl/pipe_elastic_stage.sv
// Elastic pipeline stage with a 2-entry skid buffer, global flush and
// selective kill by checkpoint mask. All outputs come straight from registers.
module pipe_elastic_stage #(
  parameter int DATA_WIDTH       = 32,
  parameter int CHECKPOINT_WIDTH = 2,
  parameter int KILL_COUNT_WIDTH = 8
) (
  input  logic                          i_Clk,
  input  logic                          i_Reset_n,
  input  logic                          i_Flush,
  input  logic                          i_Kill_Valid,
  input  logic [2**CHECKPOINT_WIDTH-1:0] i_Kill_Mask,
  input  logic                          i_Valid,
  output logic                          o_Ready,
  input  logic [DATA_WIDTH-1:0]         i_Payload,
  input  logic [CHECKPOINT_WIDTH-1:0]   i_Checkpoint,
  output logic                          o_Valid,
  input  logic                          i_Ready,
  output logic [DATA_WIDTH-1:0]         o_Payload,
  output logic [CHECKPOINT_WIDTH-1:0]   o_Checkpoint,
  output logic [1:0]                    o_Count,
  output logic [KILL_COUNT_WIDTH-1:0]   o_Kill_Count
);

  typedef struct packed {
    logic                        vld;
    logic [CHECKPOINT_WIDTH-1:0] ck;
    logic [DATA_WIDTH-1:0]       pl;
  } ent_t;

  ent_t                        out_q, skid_q, out_d, skid_d;
  ent_t [2:0]                  cand;
  logic [2:0]                  kill, surv;
  logic [1:0]                  cnt_q, nk;
  logic [KILL_COUNT_WIDTH-1:0] kcnt_q, kcnt_d;
  logic [KILL_COUNT_WIDTH:0]   ksum;
  logic                        in_xfer, out_xfer, kill_en;

  assign o_Valid      = out_q.vld;
  assign o_Ready      = ~skid_q.vld;
  assign o_Payload    = out_q.pl;
  assign o_Checkpoint = out_q.ck;
  assign o_Count      = cnt_q;
  assign o_Kill_Count = kcnt_q;

  assign in_xfer  = i_Valid & ~skid_q.vld;
  assign out_xfer = out_q.vld & i_Ready;
  assign kill_en  = i_Kill_Valid & ~i_Flush;

  // Post-transfer entries in FIFO order: held OUT, SKID, then incoming.
  // Kill applies to these, survivors compact toward OUT (at most two survive).
  always_comb begin
    cand[0] = out_xfer ? '0 : out_q;
    cand[1] = skid_q;
    cand[2] = in_xfer ? {1'b1, i_Checkpoint, i_Payload} : '0;
    for (int i = 0; i < 3; i++) begin
      kill[i] = kill_en & cand[i].vld & i_Kill_Mask[cand[i].ck];
      surv[i] = cand[i].vld & ~kill[i];
    end
    out_d = surv[0] ? cand[0] :
            surv[1] ? cand[1] :
            surv[2] ? cand[2] : '0;
    skid_d = (surv[0] & surv[1])            ? cand[1] :
             ((surv[0] ^ surv[1]) & surv[2]) ? cand[2] : '0;
    nk     = {1'b0, kill[0]} + {1'b0, kill[1]} + {1'b0, kill[2]};
    ksum   = {1'b0, kcnt_q} + (KILL_COUNT_WIDTH+1)'(nk);
    kcnt_d = ksum[KILL_COUNT_WIDTH] ? '1 : ksum[KILL_COUNT_WIDTH-1:0];
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      out_q  <= '0;
      skid_q <= '0;
      cnt_q  <= '0;
      kcnt_q <= '0;
    end else if (i_Flush) begin
      out_q  <= '0;
      skid_q <= '0;
      cnt_q  <= '0;
    end else begin
      out_q  <= out_d;
      skid_q <= skid_d;
      cnt_q  <= {1'b0, out_d.vld} + {1'b0, skid_d.vld};
      kcnt_q <= kcnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Randomized and directed bench for pipe_elastic_stage; a queue-based model of
// stage contents is the scoreboard, compared every cycle by a separate monitor.
module tb_pipe_elastic_stage;
  localparam int DW   = 32;
  localparam int CW   = 2;
  localparam int KW   = 8;
  localparam int KMAX = 2**KW - 1;

  logic             i_Clk = 1'b0, i_Reset_n = 1'b0;
  logic             i_Flush = 0, i_Kill_Valid = 0, i_Valid = 0, i_Ready = 0;
  logic [2**CW-1:0] i_Kill_Mask = '0;
  logic [DW-1:0]    i_Payload = '0;
  logic [CW-1:0]    i_Checkpoint = '0;
  logic             o_Ready, o_Valid;
  logic [DW-1:0]    o_Payload;
  logic [CW-1:0]    o_Checkpoint;
  logic [1:0]       o_Count;
  logic [KW-1:0]    o_Kill_Count;

  pipe_elastic_stage #(.DATA_WIDTH(DW), .CHECKPOINT_WIDTH(CW), .KILL_COUNT_WIDTH(KW)) dut (
    .i_Clk(i_Clk), .i_Reset_n(i_Reset_n), .i_Flush(i_Flush), .i_Kill_Valid(i_Kill_Valid),
    .i_Kill_Mask(i_Kill_Mask), .i_Valid(i_Valid), .o_Ready(o_Ready), .i_Payload(i_Payload),
    .i_Checkpoint(i_Checkpoint), .o_Valid(o_Valid), .i_Ready(i_Ready), .o_Payload(o_Payload),
    .o_Checkpoint(o_Checkpoint), .o_Count(o_Count), .o_Kill_Count(o_Kill_Count));

  always #5 i_Clk = ~i_Clk;

  typedef struct packed { logic [DW-1:0] pl; logic [CW-1:0] ck; } me_t;
  me_t mq[$];       // entries currently inside the stage, oldest first
  int  mkc;         // expected kill count
  int  n_cmp = 0, n_err = 0;
  logic last_acc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a bounded FIFO of capacity 2 with pop, push, then kill filter.
  always @(posedge i_Clk or negedge i_Reset_n) begin
    int sz, nk;
    bit ox, ix;
    if (!i_Reset_n) begin
      mq.delete();
      mkc = 0;
    end else if (i_Flush) begin
      mq.delete();
    end else begin
      sz = mq.size();
      ox = (sz > 0) && i_Ready;
      ix = i_Valid && (sz < 2);
      if (ox) void'(mq.pop_front());
      if (ix) mq.push_back(me_t'{i_Payload, i_Checkpoint});
      if (i_Kill_Valid) begin
        nk = 0;
        for (int j = mq.size() - 1; j >= 0; j--)
          if (i_Kill_Mask[mq[j].ck]) begin
            mq.delete(j);
            nk++;
          end
        mkc = (mkc + nk > KMAX) ? KMAX : mkc + nk;
      end
    end
  end

  // Monitor: DUT outputs against the model, away from the active edge.
  always @(negedge i_Clk) begin
    if (i_Reset_n) begin
      chk("o_Valid", 64'(o_Valid), 64'(mq.size() > 0));
      chk("o_Count", 64'(o_Count), 64'(mq.size()));
      chk("o_Ready", 64'(o_Ready), 64'(mq.size() < 2));
      chk("o_Kill_Count", 64'(o_Kill_Count), 64'(mkc));
      if (mq.size() > 0) begin
        chk("o_Payload", 64'(o_Payload), 64'(mq[0].pl));
        chk("o_Checkpoint", 64'(o_Checkpoint), 64'(mq[0].ck));
      end
    end
  end

  task automatic drive(input logic v, input logic [DW-1:0] pl, input logic [CW-1:0] ck,
                       input logic rdy, input logic fl = 1'b0, input logic kv = 1'b0,
                       input logic [2**CW-1:0] m = '0);
    i_Valid = v; i_Payload = pl; i_Checkpoint = ck; i_Ready = rdy;
    i_Flush = fl; i_Kill_Valid = kv; i_Kill_Mask = m;
    last_acc = v && o_Ready && !fl;
    @(posedge i_Clk);
    #1;
  endtask

  initial begin
    logic          hv;
    logic [DW-1:0] hp;
    logic [CW-1:0] hc;
    int            g;
    repeat (2) @(posedge i_Clk);
    #1 i_Reset_n = 1'b1;
    chk("reset o_Valid", 64'(o_Valid), 0);
    chk("reset o_Count", 64'(o_Count), 0);
    chk("reset o_Ready", 64'(o_Ready), 1);

    // streaming at full rate
    for (int i = 0; i < 16; i++) begin
      drive(1, DW'(32'h10 + i), 0, 1);
      chk("stream payload", 64'(o_Payload), 64'(32'h10 + i));
      chk("stream ready", 64'(o_Ready), 1);
      chk("stream count", 64'(o_Count), 1);
    end
    drive(0, 0, 0, 1);

    // backpressure fills skid, then drains in order
    drive(1, 32'hA1, 0, 0);
    drive(1, 32'hA2, 0, 0);
    chk("bp count", 64'(o_Count), 2);
    chk("bp ready", 64'(o_Ready), 0);
    chk("bp head", 64'(o_Payload), 64'h A1);
    g = 0;
    do begin drive(1, 32'hA3, 0, 1); g++; end while (!last_acc && g < 10);
    chk("bp A3 accepted", 64'(last_acc), 1);
    chk("bp tail", 64'(o_Payload), 64'hA3);
    drive(0, 0, 0, 1);

    // selective kill of OUT, SKID compacts forward
    drive(1, 32'hB1, 1, 0);
    drive(1, 32'hB2, 2, 0);
    drive(0, 0, 0, 0, 0, 1, 4'b0010);
    chk("kill payload", 64'(o_Payload), 64'hB2);
    chk("kill ckpt", 64'(o_Checkpoint), 2);
    chk("kill count", 64'(o_Count), 1);
    chk("kill kcnt", 64'(o_Kill_Count), 1);
    drive(0, 0, 0, 1);

    // departing entry survives, incoming one is killed
    drive(1, 32'hC1, 1, 0);
    drive(1, 32'hC2, 1, 1, 0, 1, 4'b0010);
    chk("killx valid", 64'(o_Valid), 0);
    chk("killx kcnt", 64'(o_Kill_Count), 2);

    // flush beats kill and input
    drive(1, 32'hD1, 3, 0);
    drive(1, 32'hD2, 3, 0);
    chk("flush pre count", 64'(o_Count), 2);
    drive(1, 32'hD3, 0, 0, 1, 1, 4'b1111);
    chk("flush count", 64'(o_Count), 0);
    chk("flush payload", 64'(o_Payload), 0);
    chk("flush valid", 64'(o_Valid), 0);
    chk("flush kcnt", 64'(o_Kill_Count), 2);

    // kill counter saturation
    repeat (300) drive(1, 32'hE0, 0, 0, 0, 1, 4'b0001);
    chk("sat kcnt", 64'(o_Kill_Count), 64'(KMAX));
    chk("sat count", 64'(o_Count), 0);

    // asynchronous reset between edges
    drive(1, 32'hF1, 0, 0);
    drive(1, 32'hF2, 0, 0);
    chk("rst pre count", 64'(o_Count), 2);
    #2 i_Reset_n = 1'b0;
    #1;
    chk("arst valid", 64'(o_Valid), 0);
    chk("arst payload", 64'(o_Payload), 0);
    chk("arst count", 64'(o_Count), 0);
    chk("arst kcnt", 64'(o_Kill_Count), 0);
    @(posedge i_Clk);
    #1 i_Reset_n = 1'b1;

    // randomized traffic; upstream holds an unaccepted entry
    hv = 0; hp = '0; hc = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!(hv && !last_acc)) begin
        hv = ($urandom_range(0, 99) < 70);
        hp = $urandom;
        hc = CW'($urandom_range(0, 2**CW - 1));
      end
      drive(hv, hp, hc, ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 3),
            ($urandom_range(0, 99) < 12), (2**CW)'($urandom));
    end
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
